// File: rtl/r2sdf_pkg.sv
// Shared constants for the R2SDF stage controller: butterfly state codes,
// default sample width and an elaboration-time clog2.
package r2sdf_pkg;

  localparam logic [1:0] ST_WAIT = 2'b00;
  localparam logic [1:0] ST_SUM  = 2'b01;
  localparam logic [1:0] ST_TWID = 2'b10;
  localparam logic [1:0] ST_IDLE = 2'b11;

  localparam int DATA_W_DEF = 24;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/r2sdf_stage_ctrl_if.sv
// Stage-controller bus: upstream samples, butterfly hookup, twiddle address and
// registered stage output. The flush handshake exists only with R2SDF_FLUSH_EN.
interface r2sdf_stage_ctrl_if #(
  parameter int DATA_W = 24,
  parameter int TW_AW  = 5
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_r;
  logic signed [DATA_W-1:0] in_i;
  logic [1:0]               bf_state;
  logic signed [DATA_W-1:0] bf_a_r;
  logic signed [DATA_W-1:0] bf_a_i;
  logic signed [DATA_W-1:0] bf_b_r;
  logic signed [DATA_W-1:0] bf_b_i;
  logic signed [DATA_W-1:0] bf_op_r;
  logic signed [DATA_W-1:0] bf_op_i;
  logic signed [DATA_W-1:0] bf_dly_r;
  logic signed [DATA_W-1:0] bf_dly_i;
  logic                     bf_outvalid;
  logic [TW_AW-1:0]         tw_addr;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_r;
  logic signed [DATA_W-1:0] out_i;
`ifdef R2SDF_FLUSH_EN
  logic                     flush;
  logic                     flush_done;
`endif

  // The stage controller is the slave; upstream, butterfly and ROM form the master side.
  modport slave (
`ifdef R2SDF_FLUSH_EN
    input  flush,
    output flush_done,
`endif
    input  in_valid, in_r, in_i,
    input  bf_op_r, bf_op_i, bf_dly_r, bf_dly_i, bf_outvalid,
    output bf_state, bf_a_r, bf_a_i, bf_b_r, bf_b_i,
    output tw_addr, out_valid, out_r, out_i
  );

  modport master (
`ifdef R2SDF_FLUSH_EN
    output flush,
    input  flush_done,
`endif
    output in_valid, in_r, in_i,
    output bf_op_r, bf_op_i, bf_dly_r, bf_dly_i, bf_outvalid,
    input  bf_state, bf_a_r, bf_a_i, bf_b_r, bf_b_i,
    input  tw_addr, out_valid, out_r, out_i
  );

endinterface

// File: rtl/r2sdf_delay_ram.sv
// Feedback delay line: DEPTH-entry circular buffer with one pointer; the entry
// at the pointer is read and then overwritten on every enabled cycle.
module r2sdf_delay_ram
  import r2sdf_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    wptr_d;

  assign rdata_o = mem[wptr_q];

  always_comb begin
    wptr_d = wptr_q;
    if (we_i) begin
      wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
    end
  end

  // Storage is never cleared; the controller's primed flag masks stale data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/r2sdf_stage_ctrl.sv
// Sequencing and feedback-delay control for one R2SDF DIF stage.
// Define R2SDF_FLUSH_EN to add the flush / flush_done drain of the final TWID half.
module r2sdf_stage_ctrl
  import r2sdf_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = 32,
  parameter int TW_AW     = 5,
  parameter int TW_STRIDE = 1
) (
  input logic              clk,
  input logic              rst,
  r2sdf_stage_ctrl_if.slave bus
);

  localparam int AW    = clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [AW-1:0] K_LAST = AW'(DEPTH - 1);

  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     primed_q;
  logic                     primed_d;
  logic                     half;
  logic [AW-1:0]            k;
  logic                     advance;
  logic                     loadOut;
  logic [1:0]               bfState;
  logic [2*DATA_W-1:0]      ramRd;
  logic                     outValid_q;
  logic signed [DATA_W-1:0] outR_q;
  logic signed [DATA_W-1:0] outI_q;
`ifdef R2SDF_FLUSH_EN
  logic                     drainCycle;
  logic                     lastDrain;
  logic                     drain_q;
  logic                     drain_d;
  logic                     flushDone_q;
`endif

  assign half = cnt_q[CNT_W-1];
  assign k    = cnt_q[AW-1:0];

  // A flush only starts inside the TWID half and loses to a real sample.
  always_comb begin
`ifdef R2SDF_FLUSH_EN
    drainCycle = drain_q || (bus.flush && !bus.in_valid && !half && primed_q);
    lastDrain  = drainCycle && (k == K_LAST);
    advance    = bus.in_valid || drainCycle;
`else
    advance    = bus.in_valid;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      primed_q <= 1'b0;
`ifdef R2SDF_FLUSH_EN
      drain_q  <= 1'b0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      primed_q <= primed_d;
`ifdef R2SDF_FLUSH_EN
      drain_q  <= drain_d;
`endif
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
`ifdef R2SDF_FLUSH_EN
    drain_d  = drain_q;
`endif
    if (advance) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (half) begin
        primed_d = 1'b1;
      end
    end
`ifdef R2SDF_FLUSH_EN
    if (drainCycle) begin
      drain_d = 1'b1;
      if (lastDrain) begin
        cnt_d    = '0;
        primed_d = 1'b0;
        drain_d  = 1'b0;
      end
    end
`endif
  end

  always_comb begin
    bfState = ST_IDLE;
    if (advance) begin
      if (half) begin
        bfState = ST_SUM;
      end else if (primed_q) begin
        bfState = ST_TWID;
      end else begin
        bfState = ST_WAIT;
      end
    end
  end

  assign bus.bf_state = bfState;
  assign bus.bf_a_r   = ramRd[2*DATA_W-1:DATA_W];
  assign bus.bf_a_i   = ramRd[DATA_W-1:0];
  assign bus.bf_b_r   = bus.in_valid ? bus.in_r : '0;
  assign bus.bf_b_i   = bus.in_valid ? bus.in_i : '0;
  assign bus.tw_addr  = (bfState == ST_TWID) ? TW_AW'(32'(k) * 32'(TW_STRIDE)) : '0;

  r2sdf_delay_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2 * DATA_W)
  ) u_delay (
    .clk     (clk),
    .rst     (rst),
    .we_i    (advance),
    .wdata_i ({bus.bf_dly_r, bus.bf_dly_i}),
    .rdata_o (ramRd)
  );

  assign loadOut = bus.bf_outvalid && advance;

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid_q <= 1'b0;
      outR_q     <= '0;
      outI_q     <= '0;
    end else begin
      outValid_q <= loadOut;
      if (loadOut) begin
        outR_q <= bus.bf_op_r;
        outI_q <= bus.bf_op_i;
      end
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_r     = outR_q;
  assign bus.out_i     = outI_q;

`ifdef R2SDF_FLUSH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      flushDone_q <= 1'b0;
    end else begin
      flushDone_q <= loadOut && lastDrain;
    end
  end

  assign bus.flush_done = flushDone_q;
`endif

endmodule
